// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multi-cycle RV32 datapath.
// It sequences lw, sw, R-type, I-type ALU and beq through fetch, decode,
// execute, memory and writeback. It also drives alu_op/func_code into the
// ALU control decoder, and all datapath selects and write strobes.
// Optional feature: define MC_ILLEGAL_TRAP_EN to add a TRAP state and a trap
// output for unsupported opcodes. Without it, an unsupported opcode is a NOP.
// MAX_WAIT = 0 disables the memory-wait timeout.
module multicycle_control #(
  parameter int MAX_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic [3:0] func_code,
  output logic       instr_retired,
  output logic       mem_timeout,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic       trap,
`endif
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  // The counter stays one bit wide when the timeout is disabled so it is never zero-width.
  localparam int              CW       = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   WAIT_LIM = CW'(MAX_WAIT);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            wait_state_s;
  logic            timeout_s;

  // Detect a memory-wait state and expiry of the wait limit; a ready memory beats the limit.
  always_comb begin
    wait_state_s = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    timeout_s    = (MAX_WAIT != 0) && wait_state_s && !mem_ready && (wait_q == WAIT_LIM);
  end

  // Next-state selection for the instruction sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout_s)      state_d = S_FETCH;
        else if (mem_ready) state_d = S_DECODE;
        else                state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECR;
          OP_ITYP:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                 state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (timeout_s)      state_d = S_FETCH;
        else if (mem_ready) state_d = S_MEMWB;
        else                state_d = S_MEMREAD;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready || timeout_s) state_d = S_FETCH;
        else                        state_d = S_MEMWRITE;
      end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Wait counter: clears on any state change or timeout, counts stalled wait cycles.
  always_comb begin
    if ((state_d != state_q) || timeout_s) begin
      wait_d = '0;
    end else if ((MAX_WAIT != 0) && wait_state_s && !mem_ready) begin
      wait_d = wait_q + CW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // State and wait-counter registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // func_code feeds the ALU control decoder regardless of state.
  always_comb begin
    if (opcode == OP_RTYP)      func_code = {funct7_5, funct3};
    else if (opcode == OP_ITYP) func_code = {1'b0, funct3};
    else                        func_code = 4'b0000;
  end

  // Datapath selects and strobes decoded from the current state; strobes are held low in reset.
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_op        = 2'b00;
    instr_retired = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write     = !timeout_s;
        instr_retired = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write      = zero;
        instr_retired = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      instr_retired = 1'b0;
    end else begin
      instr_retired = instr_retired;
    end
  end

  assign mem_timeout = timeout_s && !reset;
  assign state_o     = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign trap        = (state_q == S_TRAP) && !reset;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes hand-computed
// expected output vectors, a negedge monitor pops and compares them.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, reset_w;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready, mem_ready_w;

  logic pc_write, ir_write, reg_write, mem_write, adr_src, instr_retired, mem_timeout;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0] func_code, state_o;
  logic pc_write_w, ir_write_w, reg_write_w, mem_write_w, adr_src_w, instr_retired_w, mem_timeout_w;
  logic [1:0] alu_src_a_w, alu_src_b_w, result_src_w, alu_op_w;
  logic [3:0] func_code_w, state_o_w;
`ifdef MC_ILLEGAL_TRAP_EN
  logic trap, trap_w;
`endif

  typedef struct {
    logic [22:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t qw[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [22:0] dv, dwv;
  assign dv  = {state_o, pc_write, ir_write, reg_write, mem_write, instr_retired, mem_timeout,
                adr_src, alu_src_a, alu_src_b, result_src, alu_op, func_code};
  assign dwv = {state_o_w, pc_write_w, ir_write_w, reg_write_w, mem_write_w, instr_retired_w,
                mem_timeout_w, adr_src_w, alu_src_a_w, alu_src_b_w, result_src_w, alu_op_w, func_code_w};

  multicycle_control #(.MAX_WAIT(0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op), .func_code(func_code),
    .instr_retired(instr_retired), .mem_timeout(mem_timeout),
`ifdef MC_ILLEGAL_TRAP_EN
    .trap(trap),
`endif
    .state_o(state_o)
  );

  multicycle_control #(.MAX_WAIT(2)) dut_w (
    .clk(clk), .reset(reset_w), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready_w), .pc_write(pc_write_w), .ir_write(ir_write_w),
    .reg_write(reg_write_w), .mem_write(mem_write_w), .adr_src(adr_src_w), .alu_src_a(alu_src_a_w),
    .alu_src_b(alu_src_b_w), .result_src(result_src_w), .alu_op(alu_op_w), .func_code(func_code_w),
    .instr_retired(instr_retired_w), .mem_timeout(mem_timeout_w),
`ifdef MC_ILLEGAL_TRAP_EN
    .trap(trap_w),
`endif
    .state_o(state_o_w)
  );

  always #5 clk = ~clk;

  // Expected vector: state, strobes {pcw,irw,rw,mw,ret,tmo}, the state's select values, func_code.
  function automatic logic [22:0] ev(input logic [3:0] st, input logic [5:0] sb, input logic [3:0] fc);
    logic       adr;
    logic [1:0] a, b, rs, op;
    adr = 1'b0; a = 2'b00; b = 2'b00; rs = 2'b00; op = 2'b00;
    case (st)
      4'd0: begin b = 2'b10; rs = 2'b10; end
      4'd1: begin a = 2'b01; b = 2'b01; end
      4'd2: begin a = 2'b10; b = 2'b01; end
      4'd3: adr = 1'b1;
      4'd4: rs = 2'b01;
      4'd5: adr = 1'b1;
      4'd6: begin a = 2'b10; op = 2'b10; end
      4'd7: begin a = 2'b10; b = 2'b01; op = 2'b10; end
      4'd9: begin a = 2'b10; op = 2'b01; end
      default: adr = 1'b0;
    endcase
    return {st, sb, adr, a, b, rs, op, fc};
  endfunction

  task automatic cmp(input string nm, input logic [22:0] act, input logic [22:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic mr, input logic z, input logic [3:0] st, input logic [5:0] sb,
                      input logic [3:0] fc, input string nm);
    mem_ready = mr;
    zero      = z;
    q.push_back('{v: ev(st, sb, fc), name: nm});
    @(posedge clk); #1;
  endtask

  task automatic step_w(input logic mr, input logic [3:0] st, input logic [5:0] sb, input string nm);
    mem_ready_w = mr;
    qw.push_back('{v: ev(st, sb, 4'b0000), name: nm});
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7_5 = f7;
  endtask

  // Monitor: at each falling edge, compare outputs against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.name, dv, e.v);
    end
    if (qw.size() > 0) begin
      e = qw.pop_front();
      cmp(e.name, dwv, e.v);
    end
  end

  initial begin
    reset = 1'b1; reset_w = 1'b1; mem_ready = 1'b0; mem_ready_w = 1'b0; zero = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);
    @(posedge clk); #1;
    // reset: strobes held low even with mem_ready high
    step(1'b1, 1'b0, 4'd0, 6'b000000, 4'h0, "rst_state");
    step(1'b1, 1'b0, 4'd0, 6'b000000, 4'h0, "rst_state2");
    reset = 1'b0;

    // lw with ready memory: 0,1,2,3,4
    step(1'b1, 1'b0, 4'd0, 6'b110000, 4'h0, "lw_fetch");
    step(1'b1, 1'b0, 4'd1, 6'b000000, 4'h0, "lw_decode");
    step(1'b1, 1'b0, 4'd2, 6'b000000, 4'h0, "lw_memadr");
    step(1'b1, 1'b0, 4'd3, 6'b000000, 4'h0, "lw_memread");
    step(1'b1, 1'b0, 4'd4, 6'b001010, 4'h0, "lw_memwb");

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1);
    step(1'b1, 1'b0, 4'd0, 6'b110000, 4'h8, "sub_fetch");
    step(1'b1, 1'b0, 4'd1, 6'b000000, 4'h8, "sub_decode");
    step(1'b1, 1'b0, 4'd6, 6'b000000, 4'h8, "sub_execr");
    step(1'b1, 1'b0, 4'd8, 6'b001010, 4'h8, "sub_aluwb");

    // I-type andi: funct7_5 must not reach func_code
    set_instr(7'b0010011, 3'b111, 1'b1);
    step(1'b1, 1'b0, 4'd0, 6'b110000, 4'h7, "andi_fetch");
    step(1'b1, 1'b0, 4'd1, 6'b000000, 4'h7, "andi_decode");
    step(1'b1, 1'b0, 4'd7, 6'b000000, 4'h7, "andi_execi");
    step(1'b1, 1'b0, 4'd8, 6'b001010, 4'h7, "andi_aluwb");

    // beq taken and not taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    step(1'b1, 1'b0, 4'd0, 6'b110000, 4'h0, "beq1_fetch");
    step(1'b1, 1'b0, 4'd1, 6'b000000, 4'h0, "beq1_decode");
    step(1'b1, 1'b1, 4'd9, 6'b100010, 4'h0, "beq_taken");
    step(1'b1, 1'b1, 4'd0, 6'b110000, 4'h0, "beq0_fetch");
    step(1'b1, 1'b1, 4'd1, 6'b000000, 4'h0, "beq0_decode");
    step(1'b1, 1'b0, 4'd9, 6'b000010, 4'h0, "beq_not_taken");

    // sw with one fetch stall and three memory-write stalls
    set_instr(7'b0100011, 3'b010, 1'b0);
    step(1'b0, 1'b0, 4'd0, 6'b000000, 4'h0, "sw_fetch_stall");
    step(1'b1, 1'b0, 4'd0, 6'b110000, 4'h0, "sw_fetch");
    step(1'b1, 1'b0, 4'd1, 6'b000000, 4'h0, "sw_decode");
    step(1'b1, 1'b0, 4'd2, 6'b000000, 4'h0, "sw_memadr");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd5, 6'b000100, 4'h0, "sw_memwrite_wait");
    step(1'b1, 1'b0, 4'd5, 6'b000110, 4'h0, "sw_memwrite_done");

    // unsupported opcode
    set_instr(7'b1111111, 3'b000, 1'b0);
    step(1'b1, 1'b0, 4'd0, 6'b110000, 4'h0, "ill_fetch");
    step(1'b1, 1'b0, 4'd1, 6'b000000, 4'h0, "ill_decode");
`ifdef MC_ILLEGAL_TRAP_EN
    cmp("trap_set", {22'd0, trap}, 23'd1);
    step(1'b1, 1'b0, 4'd10, 6'b000000, 4'h0, "ill_trap");
    step(1'b1, 1'b0, 4'd10, 6'b000000, 4'h0, "ill_trap_hold");
    cmp("trap_hold", {22'd0, trap}, 23'd1);
    reset = 1'b1;
    step(1'b1, 1'b0, 4'd0, 6'b000000, 4'h0, "trap_reset");
    reset = 1'b0;
`else
    step(1'b0, 1'b0, 4'd0, 6'b000000, 4'h0, "ill_nop_fetch");
`endif

    // async reset while stalled in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    step(1'b1, 1'b0, 4'd0, 6'b110000, 4'h0, "rlw_fetch");
    step(1'b1, 1'b0, 4'd1, 6'b000000, 4'h0, "rlw_decode");
    step(1'b1, 1'b0, 4'd2, 6'b000000, 4'h0, "rlw_memadr");
    step(1'b0, 1'b0, 4'd3, 6'b000000, 4'h0, "rlw_memread_wait");
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    cmp("async_reset", dv, ev(4'd0, 6'b000000, 4'h0));
    step(1'b1, 1'b0, 4'd0, 6'b000000, 4'h0, "rlw_reset_hold");
    reset = 1'b0;
    step(1'b1, 1'b0, 4'd0, 6'b110000, 4'h0, "rlw_refetch");
    step(1'b1, 1'b0, 4'd1, 6'b000000, 4'h0, "rlw_redecode");

    // MAX_WAIT=2 instance: timeout in the 3rd stalled fetch, then ready wins at the limit
    reset_w = 1'b0;
    step_w(1'b0, 4'd0, 6'b000000, "tmo_wait0");
    step_w(1'b0, 4'd0, 6'b000000, "tmo_wait1");
    step_w(1'b0, 4'd0, 6'b000001, "tmo_pulse");
    step_w(1'b0, 4'd0, 6'b000000, "tmo_restart0");
    step_w(1'b0, 4'd0, 6'b000000, "tmo_restart1");
    step_w(1'b1, 4'd0, 6'b110000, "tmo_ready_wins");
    step_w(1'b0, 4'd1, 6'b000000, "tmo_decode");
    reset_w = 1'b1;

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32 datapath. It is the producer side of the ALU-control interface.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU and beq.
- Drives alu_op and func_code into the ALU control decoder, plus all datapath mux selects and write strobes.
- Stalls on a memory ready handshake.

Parameters:
- MAX_WAIT, 0, memory-wait cycle limit per access; 0 = unlimited, nonzero = timeout enabled.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- funct7_5  input  1  instr[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  PC load strobe
- ir_write  output  1  instruction register load strobe
- reg_write  output  1  register file write strobe
- mem_write  output  1  data memory write request
- adr_src  output  1  memory address: 0=PC, 1=ALUOut
- alu_src_a  output  2  00=PC, 01=oldPC, 10=rs1
- alu_src_b  output  2  00=rs2, 01=imm, 10=const 4
- result_src  output  2  00=ALUOut, 01=mem data, 10=ALU result
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded
- func_code  output  4  R-type: {funct7_5,funct3}; I-type: {0,funct3}; else 0
- instr_retired  output  1  one-cycle pulse when an instruction completes
- mem_timeout  output  1  one-cycle pulse on wait-limit expiry
- state_o  output  4  current state encoding, for debug

Behaviour:
- Outputs decode combinationally from the state register. Only pc_write/ir_write (FETCH), mem_write (MEMWRITE) and pc_write (BEQ) also depend on inputs.
- While reset is high:
  - state = FETCH, wait counter = 0.
  - All strobes (pc_write, ir_write, reg_write, mem_write, instr_retired, mem_timeout) forced to 0.
  - Selects take FETCH values: adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - func_code follows its combinational rule.
- A reset assertion mid-instruction aborts it. The first state after release is FETCH.
- States and encodings, with outputs and transitions:
  - FETCH (0): adr_src=0, a=00, b=10, alu_op=00, result_src=10. Stays in FETCH until mem_ready. On mem_ready: ir_write=1, pc_write=1 (PC+4), go to DECODE.
  - DECODE (1): a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - other -> see Optional Feature
  - MEMADR (2): a=10, b=01, alu_op=00. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD (3): adr_src=1. Waits for mem_ready, then MEMWB.
  - MEMWB (4): result_src=01, reg_write=1, then FETCH.
  - MEMWRITE (5): adr_src=1, mem_write=1 held until mem_ready, then FETCH.
  - EXECR (6): a=10, b=00, alu_op=10, then ALUWB.
  - EXECI (7): a=10, b=01, alu_op=10, then ALUWB.
  - ALUWB (8): result_src=00, reg_write=1, then FETCH.
  - BEQ (9): a=10, b=00, alu_op=01, result_src=00, pc_write=zero, then FETCH.
- Unlisted outputs are 0 in each state.
- instr_retired = 1 in the cycle whose next state is FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
- Memory wait (only when MAX_WAIT != 0):
  - Counter increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0, and clears on every state change.
  - When the counter reaches MAX_WAIT with mem_ready still 0: pulse mem_timeout, go to FETCH, no strobes asserted that cycle.
  - mem_ready=1 in the same cycle as the limit: ready wins, normal transition.
- Counter width: clog2(MAX_WAIT+1).

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined:
  - Adds TRAP state (10) and output trap (1 bit).
  - Unsupported opcode in DECODE -> TRAP.
  - In TRAP: trap=1, all strobes 0, stays in TRAP until reset.
- Undefined:
  - Unsupported opcode in DECODE -> FETCH, behaving as a NOP.
  - No instr_retired pulse; no trap port.

Test Plan:
- Reset, then mem_ready=1 every cycle, lw (opcode 0000011) -> states 0,1,2,3,4,0; reg_write only in state 4; one instr_retired; 5 cycles total.
- R-type sub: funct7_5=1, funct3=000 -> EXECR shows alu_op=10, func_code=1000. ALUWB reg_write=1. 4 cycles.
- beq with zero=1 -> pc_write=1 in BEQ. Repeat with zero=0 -> pc_write=0. 3 cycles each.
- sw with mem_ready held low 3 cycles in MEMWRITE (MAX_WAIT=0) -> mem_write=1 for 4 cycles, exits on the ready cycle.
- MAX_WAIT=2, mem_ready=0 in FETCH -> mem_timeout pulse in the 3rd FETCH cycle, no ir_write, state stays FETCH.
- Opcode 1111111 -> with MC_ILLEGAL_TRAP_EN: trap=1 held until reset. Without it: returns to FETCH, no instr_retired.
- Reset asserted in MEMREAD -> state_o=0 immediately (asynchronous); strobes 0.
